// File: rtl/bp_fe_pkg.sv
// Shared front-end types and helpers for the branch history table update path.
// The checkpoint entry is a macro so each user can size it by its own index width.
`ifndef BP_FE_BHT_CKPT_ENTRY_S_DEFINED
`define BP_FE_BHT_CKPT_ENTRY_S_DEFINED
`define BP_FE_BHT_CKPT_ENTRY_S(idx_width) \
    typedef struct packed {                \
        logic [idx_width-1:0] idx;         \
        logic                 pred;        \
    } bp_fe_bht_ckpt_entry_s
`endif

package bp_fe_pkg;

    // A prediction is correct when the predicted and actual directions agree.
    function automatic logic bht_correct(input logic pred, input logic taken);
        return pred ~^ taken;
    endfunction

endpackage

// File: rtl/bp_fe_bht_ckpt_mem.sv
// Checkpoint storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked entirely by the owner's pointers.
module bp_fe_bht_ckpt_mem #(
    parameter int width_p = 10,
    parameter int els_p   = 8,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_bht_updater.sv
// Branch checkpoint queue: records predictions at fetch, retires them in order
// at resolution and emits one registered write per retirement to the BHT.
module bp_fe_bht_updater
    import bp_fe_pkg::*;
#(
    parameter int bht_idx_width_p = 9,
    parameter int els_p           = 8,
    localparam int ptr_width_lp   = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       enq_v_i,
    input  logic [bht_idx_width_p-1:0] enq_idx_i,
    input  logic                       enq_pred_i,
    output logic                       enq_ready_o,
    input  logic                       res_v_i,
    input  logic                       res_taken_i,
    input  logic                       flush_i,
    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,
    output logic [ptr_width_lp:0]      count_o,
    output logic                       err_o
);

    `BP_FE_BHT_CKPT_ENTRY_S(bht_idx_width_p);
    localparam int entry_width_lp = $bits(bp_fe_bht_ckpt_entry_s);

    logic [ptr_width_lp:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic                         w_v_q, w_v_d, correct_q, correct_d, err_q, err_d;
    logic [bht_idx_width_p-1:0]   idx_w_q, idx_w_d;
    logic                         empty, full, enq_fire, res_fire;
    bp_fe_bht_ckpt_entry_s        enq_entry, rd_entry;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ptr_width_lp-1:0] == rptr_q[ptr_width_lp-1:0])
                 & (wptr_q[ptr_width_lp] != rptr_q[ptr_width_lp]);

    assign enq_ready_o = ~full & ~flush_i;
    assign enq_fire    = enq_v_i & enq_ready_o;
    assign res_fire    = res_v_i & ~empty;

    assign enq_entry = '{idx: enq_idx_i, pred: enq_pred_i};

    bp_fe_bht_ckpt_mem #(
        .width_p (entry_width_lp),
        .els_p   (els_p)
    ) ckpt_mem (
        .clk_i    (clk_i),
        .w_v_i    (enq_fire),
        .w_addr_i (wptr_q[ptr_width_lp-1:0]),
        .w_data_i (enq_entry),
        .r_addr_i (rptr_q[ptr_width_lp-1:0]),
        .r_data_o (rd_entry)
    );

    // Flush is applied after the resolution so a retiring branch still updates the table.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        w_v_d     = 1'b0;
        idx_w_d   = '0;
        correct_d = 1'b0;
        err_d     = res_v_i & empty;

        if (enq_fire) begin
            wptr_d = wptr_q + (ptr_width_lp+1)'(1);
        end

        if (res_fire) begin
            rptr_d    = rptr_q + (ptr_width_lp+1)'(1);
            w_v_d     = 1'b1;
            idx_w_d   = rd_entry.idx;
            correct_d = bht_correct(rd_entry.pred, res_taken_i);
        end

        if (flush_i) begin
            rptr_d = wptr_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            w_v_q     <= 1'b0;
            idx_w_q   <= '0;
            correct_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            w_v_q     <= w_v_d;
            idx_w_q   <= idx_w_d;
            correct_q <= correct_d;
            err_q     <= err_d;
        end
    end

    assign w_v_o     = w_v_q;
    assign idx_w_o   = idx_w_q;
    assign correct_o = correct_q;
    assign err_o     = err_q;
    assign count_o   = wptr_q - rptr_q;

endmodule

// File: tb/tb_bp_fe_bht_updater.sv
// Directed bench for bp_fe_bht_updater: a vector table for the basic flow plus
// hand-written sequences for full, flush, wrap-around and async reset cases.
module tb_bp_fe_bht_updater;

    localparam int IdxW = 9;
    localparam int Els  = 8;
    localparam int PtrW = $clog2(Els);

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic            enq_v_i;
    logic [IdxW-1:0] enq_idx_i;
    logic            enq_pred_i;
    logic            enq_ready_o;
    logic            res_v_i;
    logic            res_taken_i;
    logic            flush_i;
    logic            w_v_o;
    logic [IdxW-1:0] idx_w_o;
    logic            correct_o;
    logic [PtrW:0]   count_o;
    logic            err_o;

    int checks   = 0;
    int failures = 0;

    bp_fe_bht_updater #(.bht_idx_width_p(IdxW), .els_p(Els)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .enq_v_i     (enq_v_i),
        .enq_idx_i   (enq_idx_i),
        .enq_pred_i  (enq_pred_i),
        .enq_ready_o (enq_ready_o),
        .res_v_i     (res_v_i),
        .res_taken_i (res_taken_i),
        .flush_i     (flush_i),
        .w_v_o       (w_v_o),
        .idx_w_o     (idx_w_o),
        .correct_o   (correct_o),
        .count_o     (count_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic            enq_v;
        logic [IdxW-1:0] idx;
        logic            pred;
        logic            res_v;
        logic            taken;
        logic            flush;
        logic            exp_w_v;
        logic [IdxW-1:0] exp_idx;
        logic            exp_correct;
        logic            exp_err;
        int              exp_count;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic enq_v, input logic [IdxW-1:0] idx, input logic pred,
                                 input logic res_v, input logic taken, input logic flush);
        enq_v_i     = enq_v;
        enq_idx_i   = idx;
        enq_pred_i  = pred;
        res_v_i     = res_v;
        res_taken_i = taken;
        flush_i     = flush;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkUpdate(input string name, input logic w_v, input logic [IdxW-1:0] idx,
                               input logic correct, input int count);
        checkOutput({name, ".w_v"}, 32'(w_v_o), 32'(w_v));
        if (w_v) begin
            checkOutput({name, ".idx"}, 32'(idx_w_o), 32'(idx));
            checkOutput({name, ".correct"}, 32'(correct_o), 32'(correct));
        end
        checkOutput({name, ".count"}, 32'(count_o), 32'(count));
    endtask

    vec_t vecs[8];
    logic [IdxW:0] sb[$];
    logic [IdxW:0] exp_e;

    initial begin
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_i = 1'b1;
        #12;
        checkOutput("reset.w_v", 32'(w_v_o), 32'd0);
        checkOutput("reset.idx", 32'(idx_w_o), 32'd0);
        checkOutput("reset.correct", 32'(correct_o), 32'd0);
        checkOutput("reset.err", 32'(err_o), 32'd0);
        checkOutput("reset.count", 32'(count_o), 32'd0);
        checkOutput("reset.ready", 32'(enq_ready_o), 32'd1);
        reset_i = 1'b0;

        // enq_v idx pred res_v taken flush | w_v idx correct err count
        vecs[0] = '{1'b1, 9'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b0, 1};
        vecs[1] = '{1'b1, 9'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b0, 2};
        vecs[2] = '{1'b1, 9'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b0, 3};
        vecs[3] = '{1'b0, 9'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'd5,  1'b1, 1'b0, 2};
        vecs[4] = '{1'b0, 9'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'd9,  1'b0, 1'b0, 1};
        vecs[5] = '{1'b0, 9'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'd12, 1'b0, 1'b0, 0};
        vecs[6] = '{1'b1, 9'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0,  1'b0, 1'b1, 1};
        vecs[7] = '{1'b0, 9'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'd3,  1'b1, 1'b0, 0};

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].enq_v, vecs[i].idx, vecs[i].pred, vecs[i].res_v, vecs[i].taken, vecs[i].flush);
            step();
            checkUpdate($sformatf("vec%0d", i), vecs[i].exp_w_v, vecs[i].exp_idx, vecs[i].exp_correct, vecs[i].exp_count);
            checkOutput($sformatf("vec%0d.err", i), 32'(err_o), 32'(vecs[i].exp_err));
        end

        // Fill to capacity, then enqueue and resolve together while full.
        for (int i = 0; i < Els; i++) begin
            applyStimulus(1'b1, 9'(20 + i), i[0], 1'b0, 1'b0, 1'b0);
            step();
        end
        checkOutput("full.count", 32'(count_o), 32'd8);
        checkOutput("full.ready", 32'(enq_ready_o), 32'd0);
        applyStimulus(1'b1, 9'd99, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        checkUpdate("fullres", 1'b1, 9'd20, 1'b0, 7);
        for (int i = 1; i < Els; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
            step();
            checkUpdate($sformatf("drain%0d", i), 1'b1, 9'(20 + i), i[0], Els - 1 - i);
        end

        // Resolve, flush and enqueue in the same cycle with four entries queued.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 9'(40 + i), 1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        applyStimulus(1'b1, 9'd77, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("flush.ready", 32'(enq_ready_o), 32'd0);
        step();
        checkUpdate("flush", 1'b1, 9'd40, 1'b1, 0);
        applyStimulus(1'b1, 9'd50, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkUpdate("postflush.enq", 1'b0, '0, 1'b0, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        checkUpdate("postflush.res", 1'b1, 9'd50, 1'b0, 0);

        // Enqueue/resolve pairs against a scoreboard, crossing the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            logic [IdxW-1:0] ridx;
            logic            rpred, rtaken;
            ridx   = IdxW'($urandom_range(0, (1 << IdxW) - 1));
            rpred  = 1'($urandom_range(0, 1));
            rtaken = 1'($urandom_range(0, 1));
            applyStimulus(1'b1, ridx, rpred, 1'b0, 1'b0, 1'b0);
            sb.push_back({ridx, rpred});
            step();
            checkOutput($sformatf("pair%0d.count", i), 32'(count_o), 32'd1);
            applyStimulus(1'b0, '0, 1'b0, 1'b1, rtaken, 1'b0);
            step();
            exp_e = sb.pop_front();
            checkUpdate($sformatf("pair%0d", i), 1'b1, exp_e[IdxW:1], exp_e[0] ~^ rtaken, 0);
        end

        // Asynchronous reset with queued entries and a resolution pending.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 9'(60 + i), 1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        checkUpdate("prereset", 1'b1, 9'd60, 1'b1, 3);
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("areset.w_v", 32'(w_v_o), 32'd0);
        checkOutput("areset.idx", 32'(idx_w_o), 32'd0);
        checkOutput("areset.correct", 32'(correct_o), 32'd0);
        checkOutput("areset.err", 32'(err_o), 32'd0);
        checkOutput("areset.count", 32'(count_o), 32'd0);
        step();
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("postreset%0d.w_v", i), 32'(w_v_o), 32'd0);
            checkOutput($sformatf("postreset%0d.count", i), 32'(count_o), 32'd0);
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
